temp_ctrl_axil_regs: RTL and testbench

TEMP_CTRL_AXIL_REGS -- requirements
Module: temp_ctrl_axil_regs

---
 rtl/temp_ctrl_axil_regs.sv | 192 +++++++++++++++++++
 tb/tb_temp_ctrl_axil_regs.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_ctrl_axil_regs.sv
`default_nettype none
// ============================================================================
//  Module   : temp_ctrl_axil_regs
//  Brief    : AXI4-Lite responder with four 32-bit RW control registers that
//             are exported directly to the temperature-control datapath.
//  Revision : 1.0 - initial release
// ============================================================================
module temp_ctrl_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    // AW channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    // W channel
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    // B channel
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    // AR channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    // R channel
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    // Register contents for the control logic
    output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl_reg3
);

    localparam int C_NUM_BYTES = C_S_AXI_DATA_WIDTH / 8;
    localparam int C_NUM_REGS  = 4;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Register file
    logic [C_S_AXI_DATA_WIDTH-1:0] r_regs [0:C_NUM_REGS-1];

    // Write path state
    logic                          r_awready;
    logic                          r_wready;
    logic                          r_bvalid;
    logic                          r_aw_lat;
    logic                          r_w_lat;
    logic [1:0]                    r_aw_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_w_data;
    logic [C_NUM_BYTES-1:0]        r_w_strb;

    // Read path state
    rd_state_t                     r_rd_state;
    rd_state_t                     w_rd_state_nxt;
    logic                          r_arready;
    logic                          r_rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

    // Handshake and next-state terms
    logic w_aw_hs;
    logic w_w_hs;
    logic w_do_write;
    logic w_b_done;
    logic w_ar_hs;
    logic w_aw_lat_nxt;
    logic w_w_lat_nxt;
    logic w_bvalid_nxt;

    // Protection bits and sub-word address bits carry no meaning here
    logic w_unused;
    assign w_unused = ^{s00_axi_awprot, s00_axi_arprot,
                        s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    assign w_aw_hs    = s00_axi_awvalid & r_awready;
    assign w_w_hs     = s00_axi_wvalid  & r_wready;
    assign w_do_write = r_aw_lat & r_w_lat;
    assign w_b_done   = r_bvalid & s00_axi_bready;
    assign w_ar_hs    = s00_axi_arvalid & r_arready;

    // The commit cycle clears both latches; readys are 0 then, so no new handshake can race it
    assign w_aw_lat_nxt = w_do_write ? 1'b0 : (r_aw_lat | w_aw_hs);
    assign w_w_lat_nxt  = w_do_write ? 1'b0 : (r_w_lat  | w_w_hs);
    assign w_bvalid_nxt = w_do_write ? 1'b1 : (w_b_done ? 1'b0 : r_bvalid);

    // Write channel handshakes, payload latches and B response
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_aw_lat  <= 1'b0;
            r_w_lat   <= 1'b0;
            r_aw_idx  <= 2'd0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
        end else begin
            r_aw_lat  <= w_aw_lat_nxt;
            r_w_lat   <= w_w_lat_nxt;
            r_bvalid  <= w_bvalid_nxt;
            // A ready is offered only while its channel is empty and no response is pending
            r_awready <= ~w_aw_lat_nxt & ~w_bvalid_nxt;
            r_wready  <= ~w_w_lat_nxt  & ~w_bvalid_nxt;
            if (w_aw_hs) begin
                r_aw_idx <= s00_axi_awaddr[3:2];
            end
            if (w_w_hs) begin
                r_w_data <= s00_axi_wdata;
                r_w_strb <= s00_axi_wstrb;
            end
        end
    end

    // Register file update, byte-lane masked by the latched strobes
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_do_write) begin
            for (int b = 0; b < C_NUM_BYTES; b++) begin
                if (r_w_strb[b]) begin
                    r_regs[r_aw_idx][b*8 +: 8] <= r_w_data[b*8 +: 8];
                end
            end
        end
    end

    // Read FSM state register
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_rd_state <= R_IDLE;
        end else begin
            r_rd_state <= w_rd_state_nxt;
        end
    end

    // Read FSM next-state: accept an address when idle, hold data until rready
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            R_IDLE:  if (w_ar_hs)        w_rd_state_nxt = R_DATA;
            R_DATA:  if (s00_axi_rready) w_rd_state_nxt = R_IDLE;
            default:                     w_rd_state_nxt = R_IDLE;
        endcase
    end

    // Read channel outputs; rdata samples the pre-edge register contents
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_rvalid  <= (w_rd_state_nxt == R_DATA);
            // arready returns one edge after the R handshake, never in the same edge
            r_arready <= (r_rd_state == R_IDLE) && (w_rd_state_nxt == R_IDLE);
            if (w_ar_hs) begin
                r_rdata <= r_regs[s00_axi_araddr[3:2]];
            end
        end
    end

    assign s00_axi_awready = r_awready;
    assign s00_axi_wready  = r_wready;
    assign s00_axi_bvalid  = r_bvalid;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_arready = r_arready;
    assign s00_axi_rvalid  = r_rvalid;
    assign s00_axi_rdata   = r_rdata;
    assign s00_axi_rresp   = 2'b00;

    assign ctrl_reg0 = r_regs[0];
    assign ctrl_reg1 = r_regs[1];
    assign ctrl_reg2 = r_regs[2];
    assign ctrl_reg3 = r_regs[3];

endmodule
`default_nettype wire

// File: tb/tb_temp_ctrl_axil_regs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_temp_ctrl_axil_regs
//  Brief    : Directed self-checking bench for temp_ctrl_axil_regs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_temp_ctrl_axil_regs;

    logic        clk;
    logic        rst_n;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] creg0, creg1, creg2, creg3;

    int n_cmp  = 0;
    int n_fail = 0;

    temp_ctrl_axil_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4)
    ) u_dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .ctrl_reg0       (creg0),
        .ctrl_reg1       (creg1),
        .ctrl_reg2       (creg2),
        .ctrl_reg3       (creg3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge after the B handshake
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int  t;
        bit  aw_hs, w_hs;
        awaddr = addr; awvalid = 1'b1;
        wdata  = data; wstrb   = strb; wvalid = 1'b1;
        bready = 1'b1;
        t = 0;
        while ((awvalid || wvalid) && t < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(negedge clk);
            t++;
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        t = 0;
        while (!bvalid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("wr_bvalid", {31'd0, bvalid}, 32'd1);
        check("wr_bresp", {30'd0, bresp}, 32'd0);
        @(negedge clk);
        bready = 1'b0;
        check("wr_bvalid_fall", {31'd0, bvalid}, 32'd0);
    endtask

    // Called at a negedge; returns at a negedge after the R handshake
    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        int t;
        araddr = addr; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("rd_arready", {31'd0, arready}, 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        check("rd_rvalid", {31'd0, rvalid}, 32'd1);
        check("rd_rresp", {30'd0, rresp}, 32'd0);
        data   = rdata;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("rd_rvalid_fall", {31'd0, rvalid}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        rst_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_wready",  {31'd0, wready},  32'd0);
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_bvalid",  {31'd0, bvalid},  32'd0);
        check("rst_rvalid",  {31'd0, rvalid},  32'd0);
        check("rst_rdata",   rdata, 32'd0);
        check("rst_creg0",   creg0, 32'd0);
        check("rst_creg3",   creg3, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_awready", {31'd0, awready}, 32'd1);
        check("rel_wready",  {31'd0, wready},  32'd1);
        check("rel_arready", {31'd0, arready}, 32'd1);

        // ---------------- basic write / readback ----------------
        axi_write(4'h0, 32'h1, 4'hF);
        axi_write(4'h4, 32'h2, 4'hF);
        axi_write(4'h8, 32'h3, 4'hF);
        axi_write(4'hC, 32'h4, 4'hF);
        axi_read(4'h0, rd); check("rb_reg0", rd, 32'h1);
        axi_read(4'h4, rd); check("rb_reg1", rd, 32'h2);
        axi_read(4'h8, rd); check("rb_reg2", rd, 32'h3);
        axi_read(4'hC, rd); check("rb_reg3", rd, 32'h4);
        check("creg0_1", creg0, 32'h1);
        check("creg1_2", creg1, 32'h2);
        check("creg2_3", creg2, 32'h3);
        check("creg3_4", creg3, 32'h4);

        // ---------------- AW three cycles ahead of W ----------------
        awaddr = 4'h8; awvalid = 1'b1;
        @(negedge clk);                         // AW handshake edge passed
        awvalid = 1'b0;
        check("awlead_awready", {31'd0, awready}, 32'd0);
        check("awlead_wready",  {31'd0, wready},  32'd1);
        @(negedge clk);
        @(negedge clk);
        check("awlead_noupd", creg2, 32'h3);
        check("awlead_nob",   {31'd0, bvalid}, 32'd0);
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);                         // W handshake edge passed
        wvalid = 1'b0;
        check("awlead_wready0", {31'd0, wready}, 32'd0);
        check("awlead_noupd2",  creg2, 32'h3);
        check("awlead_nob2",    {31'd0, bvalid}, 32'd0);
        @(negedge clk);                         // commit edge passed
        check("awlead_upd",   creg2, 32'hDEADBEEF);
        check("awlead_bv",    {31'd0, bvalid}, 32'd1);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("awlead_bfall", {31'd0, bvalid}, 32'd0);
        @(negedge clk);
        check("awlead_bonce", {31'd0, bvalid}, 32'd0);
        axi_read(4'h8, rd); check("awlead_rb", rd, 32'hDEADBEEF);

        // ---------------- partial strobe ----------------
        axi_write(4'h4, 32'h11223344, 4'hF);
        axi_write(4'h4, 32'hAABBCCDD, 4'b0011);
        check("strb_creg1", creg1, 32'h1122CCDD);
        axi_read(4'h4, rd); check("strb_rb", rd, 32'h1122CCDD);

        // ---------------- B back-pressure ----------------
        awaddr = 4'hC; wdata = 32'h0A0A0A0A; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);                         // both handshakes
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);                         // commit
        check("bp_bv", {31'd0, bvalid}, 32'd1);
        wdata = 32'h0B0B0B0B; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_bv_hold", {31'd0, bvalid},  32'd1);
            check("bp_awready", {31'd0, awready}, 32'd0);
            check("bp_wready",  {31'd0, wready},  32'd0);
        end
        check("bp_creg3_first", creg3, 32'h0A0A0A0A);
        bready = 1'b1;
        @(negedge clk);                         // B handshake edge
        check("bp_bfall",     {31'd0, bvalid},  32'd0);
        check("bp_awready1",  {31'd0, awready}, 32'd1);
        check("bp_wready1",   {31'd0, wready},  32'd1);
        check("bp_creg3_keep", creg3, 32'h0A0A0A0A);
        @(negedge clk);                         // second write handshakes
        awvalid = 1'b0; wvalid = 1'b0;
        check("bp2_awready0", {31'd0, awready}, 32'd0);
        @(negedge clk);                         // second commit
        check("bp2_bv",    {31'd0, bvalid}, 32'd1);
        check("bp2_creg3", creg3, 32'h0B0B0B0B);
        @(negedge clk);
        bready = 1'b0;
        check("bp2_bfall", {31'd0, bvalid}, 32'd0);

        // ---------------- same-edge read and write ----------------
        axi_write(4'h0, 32'h5, 4'hF);
        awaddr = 4'h0; wdata = 32'h9; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);                         // AW/W handshake
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 4'h0; arvalid = 1'b1;
        @(negedge clk);                         // commit and AR handshake together
        arvalid = 1'b0;
        check("same_rvalid", {31'd0, rvalid}, 32'd1);
        check("same_rdata",  rdata, 32'h5);
        check("same_creg0",  creg0, 32'h9);
        check("same_bv",     {31'd0, bvalid}, 32'd1);
        rready = 1'b1; bready = 1'b1;
        @(negedge clk);
        rready = 1'b0; bready = 1'b0;
        check("same_rfall",   {31'd0, rvalid},  32'd0);
        check("same_arready0", {31'd0, arready}, 32'd0);
        @(negedge clk);
        check("same_arready1", {31'd0, arready}, 32'd1);
        axi_read(4'h0, rd); check("same_rb_new", rd, 32'h9);

        // ---------------- reset mid-transaction ----------------
        awaddr = 4'h4; awvalid = 1'b1;
        @(negedge clk);                         // AW handshake
        awvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_creg0",   creg0, 32'd0);
        check("mid_rst_creg2",   creg2, 32'd0);
        check("mid_rst_awready", {31'd0, awready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rel_bvalid",  {31'd0, bvalid},  32'd0);
        check("mid_rel_awready", {31'd0, awready}, 32'd1);
        check("mid_rel_wready",  {31'd0, wready},  32'd1);
        check("mid_rel_arready", {31'd0, arready}, 32'd1);
        check("mid_rel_rvalid",  {31'd0, rvalid},  32'd0);
        // W alone must not complete the abandoned write
        wdata = 32'h77777777; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_no_bvalid", {31'd0, bvalid}, 32'd0);
        check("mid_creg1",     creg1, 32'd0);
        check("mid_creg3",     creg3, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
